// File: rtl/fir_axil_cfg_master.sv
// -----------------------------------------------------------------------------
// fir_axil_cfg_master
//   AXI-Lite initiator that programs and launches the FIR engine on its own:
//   writes the data length (0x10), every tap coefficient (0x20 + 4k), sets
//   ap_start (0x00 <- 1), then polls 0x00 until ap_done (bit 1) is seen or the
//   poll budget runs out.
//
// Optional feature (macro FIR_CFG_VERIFY_EN):
//   After the last tap write, each tap register is read back and compared
//   with tap_coef. The first mismatch flags err and ends the sequence without
//   writing ap_start.
//
// Ports:
//   axis_clk, axis_rst_n    clock, asynchronous active-low reset
//   cfg_start, cfg_len      start request (ignored while busy) and data length
//   tap_idx, tap_coef       tap index presented, coefficient returned for it
//   busy, done, err         status: in progress, one-cycle end pulse, error
//   aw*/w*                  AXI-Lite write address / write data channels
//   ar*/r*                  AXI-Lite read address / read data channels
//   dbg_state               current FSM state
//
// Handshake: a channel transfers on the rising edge where valid && ready are
//   both high; valid and its payload stay stable until then and drop on the
//   following cycle. Only one transaction (read or write) is ever in flight.
// -----------------------------------------------------------------------------
module fir_axil_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pPOLL_GAP   = 8,
  parameter int pPOLL_MAX   = 4096
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_len,
  output logic [3:0]             tap_idx,
  input  logic [31:0]            tap_coef,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic [2:0]             dbg_state
);

  localparam int PCW = $clog2(pPOLL_MAX + 1);
  localparam int GW  = $clog2(pPOLL_GAP + 1);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_LEN    = 3'd1,
    WR_TAP    = 3'd2,
    WR_START  = 3'd3,
    POLL_RD   = 3'd4,
    POLL_WAIT = 3'd5,
`ifdef FIR_CFG_VERIFY_EN
    VERIFY    = 3'd7,
`endif
    FINISH    = 3'd6
  } state_t;

  state_t                 state_q;
  logic [31:0]            len_q;
  logic [3:0]             tap_idx_q;
  logic                   busy_q, done_q, err_q;
  logic                   awvalid_q, wvalid_q, arvalid_q, rready_q;
  logic [pADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [pDATA_WIDTH-1:0] wdata_q;
  logic                   txn_q;      // a transaction of the current state is open
  logic                   aw_done_q, w_done_q;
  logic [PCW-1:0]         poll_cnt_q;
  logic [GW-1:0]          gap_q;

  logic                   is_wr_d, is_rd_d;
  logic [pADDR_WIDTH-1:0] wr_addr_d, rd_addr_d, tap_addr;
  logic [pDATA_WIDTH-1:0] wr_data_d;
  logic                   aw_hs, w_hs, ar_hs, r_hs, wr_complete, last_tap;

  assign aw_hs    = awvalid_q && awready;
  assign w_hs     = wvalid_q && wready;
  assign ar_hs    = arvalid_q && arready;
  assign r_hs     = rready_q && rvalid;
  // Both channels may finish in either order; completion needs both.
  assign wr_complete = txn_q && (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign last_tap = (tap_idx_q == 4'(Tape_Num - 1));
  assign tap_addr = pADDR_WIDTH'(32'h20 + (32'(tap_idx_q) << 2));

`ifndef FIR_CFG_VERIFY_EN
  // Only the ap_done bit of rdata matters without read-back verification.
  logic unused_rdata;
  assign unused_rdata = ^rdata;
`endif

  // Address/payload of the transaction the current state issues.
  always_comb begin
    is_wr_d   = 1'b0;
    is_rd_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    rd_addr_d = '0;
    case (state_q)
      WR_LEN:   begin is_wr_d = 1'b1; wr_addr_d = ADDR_LEN;  wr_data_d = pDATA_WIDTH'(len_q); end
      WR_TAP:   begin is_wr_d = 1'b1; wr_addr_d = tap_addr;  wr_data_d = pDATA_WIDTH'(tap_coef); end
      WR_START: begin is_wr_d = 1'b1; wr_addr_d = ADDR_CTRL; wr_data_d = pDATA_WIDTH'(1); end
      POLL_RD:  begin is_rd_d = 1'b1; rd_addr_d = ADDR_CTRL; end
`ifdef FIR_CFG_VERIFY_EN
      VERIFY:   begin is_rd_d = 1'b1; rd_addr_d = tap_addr; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      tap_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      txn_q      <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      poll_cnt_q <= '0;
      gap_q      <= '0;
    end else begin
      done_q <= 1'b0;

      // Channel bookkeeping shared by every read/write state.
      if (aw_hs) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
      if (w_hs)  begin wvalid_q  <= 1'b0; w_done_q  <= 1'b1; end
      if (ar_hs) begin arvalid_q <= 1'b0; rready_q  <= 1'b1; end
      if (r_hs)  rready_q <= 1'b0;

      // Open a new transaction on the first cycle of a read/write state.
      if (is_wr_d && !txn_q) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= wr_addr_d;
        wdata_q   <= wr_data_d;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        txn_q     <= 1'b1;
      end
      if (is_rd_d && !txn_q) begin
        arvalid_q <= 1'b1;
        araddr_q  <= rd_addr_d;
        txn_q     <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            len_q   <= cfg_len;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WR_LEN;
          end
        end
        WR_LEN: begin
          if (wr_complete) begin
            txn_q     <= 1'b0;
            tap_idx_q <= '0;
            state_q   <= WR_TAP;
          end
        end
        WR_TAP: begin
          if (wr_complete) begin
            txn_q <= 1'b0;
            if (last_tap) begin
`ifdef FIR_CFG_VERIFY_EN
              tap_idx_q <= '0;
              state_q   <= VERIFY;
`else
              state_q   <= WR_START;
`endif
            end else begin
              tap_idx_q <= tap_idx_q + 4'd1;
            end
          end
        end
`ifdef FIR_CFG_VERIFY_EN
        VERIFY: begin
          if (r_hs) begin
            txn_q <= 1'b0;
            if (rdata != pDATA_WIDTH'(tap_coef)) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FINISH;
            end else if (last_tap) begin
              state_q <= WR_START;
            end else begin
              tap_idx_q <= tap_idx_q + 4'd1;
            end
          end
        end
`endif
        WR_START: begin
          if (wr_complete) begin
            txn_q      <= 1'b0;
            poll_cnt_q <= '0;
            state_q    <= POLL_RD;
          end
        end
        POLL_RD: begin
          if (r_hs) begin
            txn_q <= 1'b0;
            if (rdata[1]) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FINISH;
            end else if (poll_cnt_q == PCW'(pPOLL_MAX - 1)) begin
              // This read used up the budget: give up with an error.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FINISH;
            end else begin
              poll_cnt_q <= poll_cnt_q + PCW'(1);
              gap_q      <= '0;
              state_q    <= POLL_WAIT;
            end
          end
        end
        POLL_WAIT: begin
          if (gap_q == GW'(pPOLL_GAP - 1)) state_q <= POLL_RD;
          else                              gap_q   <= gap_q + GW'(1);
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tap_idx   = tap_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_axil_cfg_master.sv
`timescale 1ns/1ps
module tb_fir_axil_cfg_master;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int NT   = 11;
  localparam int GAP  = 8;
  localparam int PMAX = 4;
  localparam int EW   = 2 + AW + DW;   // {kind, addr, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_start, busy, done, err;
  logic [31:0]   cfg_len, tap_coef;
  logic [3:0]    tap_idx;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [2:0]    dbg_state;

  fir_axil_cfg_master #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT), .pPOLL_GAP(GAP), .pPOLL_MAX(PMAX)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .tap_idx(tap_idx), .tap_coef(tap_coef), .busy(busy), .done(done), .err(err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .dbg_state(dbg_state)
  );

  logic [31:0] coef [0:15];
  assign tap_coef = (tap_idx < 4'(NT)) ? coef[tap_idx] : 32'h0;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0h with nothing expected", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, got, e);
      end
    end
  endtask

  // Reference model: the full bus trace of one sequence, from the rules.
  task automatic push_model(input logic [31:0] len, input int zeros, input int cidx,
                            input logic [31:0] cxor);
    bit bad = 0;
    int nreads;
    exp_q.push_back({2'b00, 12'h010, len});
    for (int k = 0; k < NT; k++) exp_q.push_back({2'b00, 12'(32'h20 + 4 * k), coef[k]});
`ifdef FIR_CFG_VERIFY_EN
    for (int k = 0; k < NT; k++) begin
      exp_q.push_back({2'b01, 12'(32'h20 + 4 * k), 32'h0});
      if (k == cidx && cxor != 0) begin bad = 1; break; end
    end
`endif
    if (bad) begin
      exp_q.push_back({2'b10, 12'h0, 32'h1});
      return;
    end
    exp_q.push_back({2'b00, 12'h000, 32'h1});
    nreads = (zeros < PMAX) ? zeros + 1 : PMAX;
    for (int i = 0; i < nreads; i++) exp_q.push_back({2'b01, 12'h000, 32'h0});
    exp_q.push_back({2'b10, 12'h0, (zeros >= PMAX) ? 32'h1 : 32'h0});
  endtask

  // ---------------- responder + monitor (negedge) ----------------
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  bit rand_dly = 0;
  int st_zeros = 0, st_seen = 0;
  logic [31:0] done_status = 32'h6;
  int corrupt_idx = -1;
  logic [31:0] corrupt_xor = 32'h0;
  logic [31:0] mem [0:15];
  int done_cnt = 0;
  int cyc = 0;
  int last_st_hs = -1;

  int aw_cnt, w_cnt, ar_cnt, r_cnt, aw_hi, w_hi;
  bit aw_got, w_got, r_pend, r_hs_prev;
  bit awv_p, wv_p, arv_p, aw_hs_p, w_hs_p, ar_hs_p;
  logic [AW-1:0] awaddr_p, araddr_p, got_addr, r_addr;
  logic [DW-1:0] wdata_p, got_data;
  int idx;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; aw_hi = 0; w_hi = 0;
      aw_got = 0; w_got = 0; r_pend = 0; r_hs_prev = 0;
      awv_p = 0; wv_p = 0; arv_p = 0; aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0;
    end else begin
      // valid/payload must stay put until accepted
      if (awv_p && !aw_hs_p) check("aw_stable", {awvalid, awaddr}, {1'b1, awaddr_p});
      if (wv_p && !w_hs_p)   check("w_stable", {wvalid, wdata}, {1'b1, wdata_p});
      if (arv_p && !ar_hs_p) check("ar_stable", {arvalid, araddr}, {1'b1, araddr_p});
      if (awvalid && !awv_p) begin
        check("aw_w_together", wvalid && !wv_p, 1);
        check("wr_overlap", {aw_got, w_got, r_pend, arvalid}, 0);
      end
      if (arvalid && !arv_p) begin
        check("rd_overlap", {aw_got, w_got, r_pend, awvalid, wvalid}, 0);
        if (araddr == 12'h000 && last_st_hs >= 0)
          check("poll_gap", (cyc - last_st_hs - 1) >= GAP, 1);
      end

      // read data for an address accepted on an earlier edge
      if (r_hs_prev) begin rvalid = 0; rdata = '0; end
      r_hs_prev = 0;
      if (r_pend && !rvalid) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1;
          if (r_addr == 12'h000) begin
            rdata = (st_seen < st_zeros) ? ($urandom & ~32'h2) : done_status;
            st_seen++;
          end else begin
            idx = (int'(r_addr) - 32) / 4;
            rdata = mem[idx] ^ ((idx == corrupt_idx) ? corrupt_xor : 32'h0);
          end
        end else r_cnt++;
      end

      awready = 0;
      if (awvalid) begin if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++; end
      wready = 0;
      if (wvalid) begin if (w_cnt >= w_dly) wready = 1; else w_cnt++; end
      arready = 0;
      if (arvalid) begin if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++; end
      aw_hi = awvalid ? aw_hi + 1 : 0;
      w_hi  = wvalid ? w_hi + 1 : 0;

      // handshakes happening at the coming rising edge
      if (awvalid && awready) begin
        check("aw_valid_len", aw_hi, aw_dly + 1);
        aw_got = 1; got_addr = awaddr; aw_cnt = 0;
        if (rand_dly) aw_dly = $urandom_range(0, 3);
      end
      if (wvalid && wready) begin
        check("w_valid_len", w_hi, w_dly + 1);
        w_got = 1; got_data = wdata; w_cnt = 0;
        if (rand_dly) w_dly = $urandom_range(0, 3);
      end
      if (aw_got && w_got) begin
        sb_compare("write", {2'b00, got_addr, got_data});
        if (got_addr >= 12'h020) mem[(int'(got_addr) - 32) / 4] = got_data;
        aw_got = 0; w_got = 0;
      end
      if (arvalid && arready) begin
        sb_compare("read_addr", {2'b01, araddr, 32'h0});
        r_pend = 1; r_addr = araddr; r_cnt = 0; ar_cnt = 0;
        if (rand_dly) begin ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); end
      end
      if (rvalid && rready) begin
        r_pend = 0; r_hs_prev = 1;
        if (r_addr == 12'h000) last_st_hs = cyc;
      end
      if (done) begin
        check("busy_at_done", busy, 0);
        sb_compare("done_err", {2'b10, 12'h0, 31'h0, err});
        done_cnt++;
      end

      awv_p = awvalid; wv_p = wvalid; arv_p = arvalid;
      aw_hs_p = awvalid && awready; w_hs_p = wvalid && wready; ar_hs_p = arvalid && arready;
      awaddr_p = awaddr; wdata_p = wdata; araddr_p = araddr;
    end
  end

  // ---------------- driver tasks ----------------
  int start_done;

  task automatic start_seq(input logic [31:0] len, input int zeros, input logic [31:0] dstat,
                           input int cidx, input logic [31:0] cxor);
    st_zeros = zeros; st_seen = 0; done_status = dstat;
    corrupt_idx = cidx; corrupt_xor = cxor; last_st_hs = -1;
    push_model(len, zeros, cidx, cxor);
    @(negedge clk);
    start_done = done_cnt;
    cfg_start = 1; cfg_len = len;
    @(negedge clk);
    cfg_start = 0; cfg_len = $urandom;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
  endtask

  task automatic wait_seq(input bit stray_start);
    int i;
    if (stray_start) begin
      repeat (20) @(negedge clk);
      cfg_start = 1; cfg_len = 32'hDEAD;   // must be ignored while busy
      @(negedge clk);
      cfg_start = 0;
    end
    for (i = 0; i < 4000 && done_cnt == start_done; i++) begin
      @(negedge clk); #1;
    end
    check("done_seen", done_cnt != start_done, 1);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_one_cycle", done, 0);
  endtask

  task automatic run_seq(input logic [31:0] len, input int zeros, input logic [31:0] dstat,
                         input int cidx, input logic [31:0] cxor, input bit stray_start);
    start_seq(len, zeros, dstat, cidx, cxor);
    wait_seq(stray_start);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int taps [0:10];
    taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    cfg_start = 0; cfg_len = '0;
    for (int k = 0; k < 16; k++) begin coef[k] = (k < NT) ? 32'(taps[k]) : 32'h0; mem[k] = '0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {awvalid, wvalid, arvalid, rready}, 0);
    check("rst_addr_data", {awaddr, araddr, wdata}, 0);
    check("rst_status", {tap_idx, busy, done, err}, 0);
    @(negedge clk) rst_n = 1;

    // zero-wait responder, directed taps
    run_seq(32'd600, 0, 32'h6, -1, 32'h0, 1'b0);
    // slow write address channel
    aw_dly = 3; w_dly = 0;
    run_seq(32'd600, 0, 32'h2, -1, 32'h0, 1'b0);
    aw_dly = 0;
    // three not-done polls then done, plus an ignored start while busy
    run_seq(32'd77, 3, 32'h2, -1, 32'h0, 1'b1);
    // poll timeout
    run_seq(32'd5, 20, 32'h2, -1, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    check("err_held", err, 1);
    // read-back corruption of tap 3 (only visible with verification enabled)
    run_seq(32'd600, 0, 32'h6, 3, 32'd23 ^ 32'd24, 1'b0);

    // randomized sequences
    rand_dly = 1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NT; k++) coef[k] = $urandom;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      run_seq($urandom, $urandom_range(0, 5), $urandom | 32'h2,
              $urandom_range(0, NT) - 1, $urandom_range(0, 1) ? ($urandom | 32'h1) : 32'h0,
              1'b0);
    end

    // reset in the middle of the tap 5 write
    start_seq(32'd1234, 0, 32'h2, -1, 32'h0);
    begin
      int i;
      for (i = 0; i < 2000; i++) begin
        @(negedge clk); #1;
        if (awvalid && awaddr == 12'h034) break;
      end
      check("reached_tap5", awvalid && awaddr == 12'h034, 1);
    end
    #1 rst_n = 0;
    #1;
    check("rst_mid_valids", {awvalid, wvalid, arvalid, rready}, 0);
    check("rst_mid_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_seq(32'd42, 1, 32'h2, -1, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
